// File: rtl/instr_feeder.sv
// instr_feeder: program sequencer for the 9-bit processor. It fetches words
// from a synchronous program ROM (data valid one cycle after the address).
// It issues each instruction on DIN with a one-cycle Run strobe, follows an
// mvi with its immediate word, and waits for Done before the next fetch.
// Optional build macro SINGLE_STEP_EN adds a Step input and an ARMED state
// that gates every instruction fetch on a Step pulse.
module instr_feeder #(
    parameter int ADDR_W       = 5,
    parameter int PROG_LEN     = 32,
    parameter int DONE_TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [8:0]        MemData,
    input  logic              Done,
`ifdef SINGLE_STEP_EN
    input  logic              Step,
`endif
    output logic [ADDR_W-1:0] MemAddr,
    output logic [8:0]        DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Error
);

    // One extra PC bit so PC==PROG_LEN is visible even when PROG_LEN==2**ADDR_W.
    localparam int PC_W  = ADDR_W + 1;
    localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);

    localparam logic [PC_W-1:0]  PC_END    = PC_W'(PROG_LEN);
    localparam logic [PC_W-1:0]  PC_LAST   = PC_W'(PROG_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DONE_TIMEOUT);
    localparam logic [2:0]       OP_MVI    = 3'b001;
    localparam logic [2:0]       OP_HALT   = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_FETCH_IMM,
        S_LATCH_IMM,
        S_ISSUE,
        S_IMM_OUT,
        S_WAIT_DONE,
        S_HALT,
        S_ARMED
    } state_t;

    // State entered whenever a new instruction is to be fetched.
`ifdef SINGLE_STEP_EN
    localparam state_t S_LOOP = S_ARMED;
`else
    localparam state_t S_LOOP = S_FETCH;
`endif

    state_t            state_q, state_d, after_done;
    logic [PC_W-1:0]   pc_q, pc_step;
    logic [8:0]        instr_q, imm_q, din_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_inc;
    logic              err_q, launch, err_set, instr_is_mvi;

    assign instr_is_mvi = (instr_q[8:6] == OP_MVI);
    assign pc_step      = instr_is_mvi ? PC_W'(2) : PC_W'(1);
    assign cnt_inc      = cnt_q + CNT_W'(1);
    assign after_done   = (pc_q >= PC_END) ? S_HALT : S_LOOP;

    // State register with synchronous reset.
    always_ff @(posedge Clock) begin
        // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decision plus one-cycle launch/error-set requests for the datapath.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d = state_q;
        launch  = 1'b0;
        err_set = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (Start) begin
                    launch  = 1'b1;
                    state_d = S_LOOP;
                end
            end
`ifdef SINGLE_STEP_EN
            S_ARMED:     if (Step) state_d = S_FETCH;
`endif
            S_FETCH:     state_d = S_LATCH;
            S_LATCH: begin
                if (MemData[8:6] == OP_HALT) begin
                    state_d = S_HALT;
                end else if (MemData[8:6] == OP_MVI) begin
                    // An mvi in the last word has no immediate: refuse to issue it.
                    if (pc_q == PC_LAST) begin
                        err_set = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH_IMM;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_FETCH_IMM: state_d = S_LATCH_IMM;
            S_LATCH_IMM: state_d = S_ISSUE;
            S_ISSUE:     state_d = instr_is_mvi ? S_IMM_OUT : S_WAIT_DONE;
            S_IMM_OUT:   state_d = Done ? after_done : S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (Done) begin
                    state_d = after_done;
                end else if (cnt_inc == CNT_LIMIT) begin
                    err_set = 1'b1;
                    state_d = S_HALT;
                end
            end
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs: ROM address and DIN hold their last value outside the states that drive them.
    always_comb begin
        MemAddr = addr_q;
        DIN     = din_q;
        case (state_q)
            S_FETCH:     MemAddr = pc_q[ADDR_W-1:0];
            S_FETCH_IMM: MemAddr = pc_q[ADDR_W-1:0] + ADDR_W'(1);
            S_ISSUE:     DIN     = instr_q;
            S_IMM_OUT:   DIN     = imm_q;
            default:     ;
        endcase
        Run    = (state_q == S_ISSUE);
        Busy   = (state_q != S_IDLE) && (state_q != S_HALT);
        Halted = (state_q == S_HALT);
        Error  = err_q;
        PC     = pc_q[ADDR_W-1:0];
    end

    // Datapath: program counter, fetched words, held outputs, Done timeout counter, sticky error.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            din_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            addr_q <= MemAddr;
            din_q  <= DIN;
            if (launch) begin
                pc_q  <= '0;
                err_q <= 1'b0;
            end
            if (err_set) err_q <= 1'b1;
            case (state_q)
                S_LATCH:     instr_q <= MemData;
                S_LATCH_IMM: imm_q   <= MemData;
                S_ISSUE: begin
                    pc_q  <= pc_q + pc_step;
                    cnt_q <= '0;
                end
                S_WAIT_DONE: if (!Done) cnt_q <= cnt_inc;
                default:     ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: directed programs plus randomized
// programs and Done latencies, compared cycle by cycle against a
// transaction-level model of the program walk.
module tb_instr_feeder;

    localparam int ADDR_W = 3;
    localparam int PLEN   = 8;
    localparam int DT     = 5;
    localparam int NEVER  = 1000;
    localparam int MAXC   = 256;

    logic              Clock, Reset, Start, Done;
    logic [8:0]        MemData;
    logic [ADDR_W-1:0] MemAddr, PC;
    logic [8:0]        DIN;
    logic              Run, Busy, Halted, Error;

    instr_feeder #(.ADDR_W(ADDR_W), .PROG_LEN(PLEN), .DONE_TIMEOUT(DT)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .MemData(MemData), .Done(Done),
        .MemAddr(MemAddr), .DIN(DIN), .Run(Run), .PC(PC),
        .Busy(Busy), .Halted(Halted), .Error(Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous program ROM.
    logic [8:0] rom [PLEN];
    always @(posedge Clock) MemData <= rom[MemAddr];

    // Done latency (cycles after Run) for each issued instruction; NEVER = no Done.
    int lat [PLEN];

    int n_vec = 0;
    int n_err = 0;

    // Model outputs, indexed by cycle relative to the Start cycle.
    bit                exp_run  [MAXC];
    bit                done_at  [MAXC];
    bit                din_known[MAXC];
    logic [8:0]        exp_din  [MAXC];
    int                halt_t;
    logic              exp_err;
    logic [ADDR_W-1:0] exp_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Walk the program: FETCH/LATCH take 2 cycles before ISSUE, an mvi adds 2 more
    // for its immediate; Done at Run+lat resumes fetching on the next cycle.
    task automatic build_model();
        bit         set_v [MAXC];
        logic [8:0] set_d [MAXC];
        logic [8:0] w, cur;
        bit         have, fin;
        int         pc, t, r, l, k;
        for (int i = 0; i < MAXC; i++) begin
            exp_run[i] = 0; done_at[i] = 0; set_v[i] = 0; set_d[i] = '0;
        end
        pc = 0; t = 1; k = 0; fin = 0; exp_err = 0; halt_t = 0;
        while (!fin) begin
            if (pc >= PLEN) begin
                halt_t = t; fin = 1;
            end else begin
                w = rom[pc];
                if (w[8:6] == 3'b111) begin
                    halt_t = t + 2; fin = 1;
                end else if (w[8:6] == 3'b001 && pc == PLEN - 1) begin
                    halt_t = t + 2; exp_err = 1; fin = 1;
                end else if (w[8:6] == 3'b001) begin
                    r = t + 4;
                    exp_run[r] = 1;
                    set_v[r] = 1; set_d[r] = w;
                    set_v[r+1] = 1; set_d[r+1] = rom[pc+1];
                    pc += 2; l = lat[k]; k++;
                    if (l <= DT + 1) begin done_at[r+l] = 1; t = r + l + 1; end
                    else begin halt_t = r + 2 + DT; exp_err = 1; fin = 1; end
                end else begin
                    r = t + 2;
                    exp_run[r] = 1;
                    set_v[r] = 1; set_d[r] = w;
                    pc += 1; l = lat[k]; k++;
                    if (l <= DT) begin done_at[r+l] = 1; t = r + l + 1; end
                    else begin halt_t = r + 1 + DT; exp_err = 1; fin = 1; end
                end
            end
        end
        exp_pc = ADDR_W'(pc);
        have = 0; cur = '0;
        for (int i = 0; i < MAXC; i++) begin
            if (set_v[i]) begin have = 1; cur = set_d[i]; end
            din_known[i] = have;
            exp_din[i]   = cur;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " addr"},   32'(MemAddr), 32'd0);
        check({tag, " din"},    32'(DIN),     32'd0);
        check({tag, " run"},    32'(Run),     32'd0);
        check({tag, " pc"},     32'(PC),      32'd0);
        check({tag, " busy"},   32'(Busy),    32'd0);
        check({tag, " halted"}, 32'(Halted),  32'd0);
        check({tag, " error"},  32'(Error),   32'd0);
    endtask

    // Caller is at a falling edge: pulse Reset for one rising edge, then check.
    task automatic apply_reset(input string tag);
        Reset = 1'b1; Start = 1'b0; Done = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        check_zero(tag);
    endtask

    // Start the loaded program and compare every cycle until shortly after HALT.
    // abort_rel > 0 applies Reset at that relative cycle instead.
    task automatic run_scenario(input string name, input int abort_rel);
        string tg;
        build_model();
        if (halt_t > MAXC - 4) begin
            check({name, " model length"}, 32'(halt_t), 32'(MAXC - 4));
            return;
        end
        for (int rel = 0; rel <= halt_t + 2; rel++) begin
            @(negedge Clock);
            tg = $sformatf("%s c%0d", name, rel);
            if (rel == 0) begin
                check({tg, " busy"}, 32'(Busy), 32'd0);
            end else begin
                check({tg, " run"},    32'(Run),    32'(exp_run[rel]));
                check({tg, " busy"},   32'(Busy),   32'(rel < halt_t));
                check({tg, " halted"}, 32'(Halted), 32'(rel >= halt_t));
                check({tg, " error"},  32'(Error),  32'((rel >= halt_t) ? exp_err : 1'b0));
                if (din_known[rel]) check({tg, " din"}, 32'(DIN), 32'(exp_din[rel]));
                if (rel == halt_t)  check({tg, " pc"},  32'(PC),  32'(exp_pc));
            end
            if (abort_rel > 0 && rel == abort_rel) begin
                apply_reset({name, " reset"});
                return;
            end
            // Start while busy and Done during ISSUE must both be ignored.
            Start = (rel == 0) || (rel < halt_t && $urandom_range(0, 9) == 0);
            Done  = done_at[rel] || (exp_run[rel] && $urandom_range(0, 3) == 0);
        end
        Start = 1'b0;
        Done  = 1'b0;
    endtask

    function automatic logic [8:0] rand_word();
        logic [2:0] op;
        int         x;
        x = $urandom_range(0, 19);
        if (x == 0)     op = 3'b111;
        else if (x < 6) op = 3'b001;
        else            op = 3'($urandom_range(0, 6));
        return {op, 6'($urandom)};
    endfunction

    function automatic int rand_lat();
        int x;
        x = $urandom_range(0, 19);
        if (x == 0)      return NEVER;
        else if (x == 1) return DT + 1;
        else if (x == 2) return DT;
        else             return $urandom_range(1, DT);
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < PLEN; i++) begin
            rom[i] = 9'h000;
            lat[i] = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; Done = 1'b0;
        clear_prog();
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        check_zero("por");
        @(negedge Clock);
        check_zero("idle hold");

        // mvi R1,#5 then HALT; Done during IMM_OUT.
        clear_prog();
        rom[0] = 9'h048; rom[1] = 9'h005; rom[2] = 9'h1C0;
        run_scenario("mvi", 0);

        // add then HALT; Done three cycles after Run.
        clear_prog();
        rom[0] = 9'h08A; rom[1] = 9'h1C0; lat[0] = 3;
        run_scenario("add", 0);

        // sub with no Done: timeout.
        clear_prog();
        rom[0] = 9'h0C8; rom[1] = 9'h1C0; lat[0] = NEVER;
        run_scenario("timeout", 0);
        @(negedge Clock);
        apply_reset("rst err");

        // mvi in the last word is never issued.
        clear_prog();
        for (int i = 0; i < PLEN - 1; i++) rom[i] = {3'b000, 6'(i)};
        rom[PLEN-1] = 9'h048;
        run_scenario("mvi last", 0);

        // Program without HALT runs off the end.
        clear_prog();
        for (int i = 0; i < PLEN; i++) rom[i] = {3'($urandom_range(2, 6)), 6'($urandom)};
        run_scenario("run off", 0);

        // Reset while waiting for Done, then restart from IDLE.
        clear_prog();
        rom[0] = 9'h0C8; lat[0] = NEVER;
        run_scenario("rst wait", 4);
        clear_prog();
        rom[0] = 9'h0C8; rom[1] = 9'h1C0; lat[0] = 2;
        run_scenario("after rst", 0);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < PLEN; i++) begin
                rom[i] = rand_word();
                lat[i] = rand_lat();
            end
            run_scenario($sformatf("rnd%0d", n), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
